// File: rtl/seq_restoring_divider.sv
// Purpose: unsigned restoring divider (DIV/MOD unit); one quotient bit per clock through a shared WIDTH+1-bit subtractor.
// Latency: WIDTH+1 edges from the accepting edge to done, or 1 edge for a zero divisor.
// Backpressure: start is only sampled in IDLE/DONE; requests while busy are dropped, so the requester must wait for done.
module seq_restoring_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] d;
    logic [CW-1:0]    count;

    logic             accept;
    logic             last_iter;
    logic [WIDTH:0]   shifted_r;
    logic [WIDTH+1:0] sum;
    logic             cout;
    logic [WIDTH:0]   r_next;
    logic [WIDTH-1:0] q_next;
    logic             r_msb_unused;

    assign accept    = ((state == IDLE) || (state == DONE)) && start;
    assign last_iter = (state == CALC) && (count == CW'(1));

    // Trial subtract as add of ~D with carry-in; carry out set means no borrow.
    assign shifted_r = {r[WIDTH-1:0], q[WIDTH-1]};
    assign sum       = {1'b0, shifted_r} + {1'b0, ~{1'b0, d}} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign cout      = sum[WIDTH+1];
    assign r_next    = cout ? sum[WIDTH:0] : shifted_r;
    assign q_next    = {q[WIDTH-2:0], cout};

    // R stays below D after every iteration, so its top bit never feeds the shift.
    assign r_msb_unused = r[WIDTH];

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end else begin
                    state_next = IDLE;
                end
            end
            CALC: begin
                if (count == CW'(1)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            count       <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else begin
                r           <= '0;
                q           <= dividend;
                d           <= divisor;
                count       <= CW'(WIDTH);
                div_by_zero <= 1'b0;
            end
        end else if (state == CALC) begin
            r     <= r_next;
            q     <= q_next;
            count <= count - CW'(1);
            if (last_iter) begin
                quotient  <= q_next;
                remainder <= r_next[WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed vector table, handshake corner cases, random regression.
module tb_seq_restoring_divider;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    seq_restoring_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    // Samples on falling edges until done; lat counts edges from the accepting edge.
    task automatic wait_done(output int lat, output int nb, output bit held);
        logic [W-1:0] hq;
        logic [W-1:0] hr;
        hq = quotient;
        hr = remainder;
        held = 1'b1;
        lat = 0;
        nb = 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) nb++;
            if (!done && (quotient !== hq || remainder !== hr)) held = 1'b0;
        end while (!done && lat < 64);
    endtask

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int nb, output bit held);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, nb, held);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            default: return W'($urandom_range(0, (1 << W) - 1));
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t tbl[6];
        int   lat;
        int   nb;
        bit   held;
        bit   saw_done;

        tbl[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0};
        tbl[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0};
        tbl[2] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0};
        tbl[3] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0};
        tbl[4] = '{8'd37,  8'd0,   8'd255, 8'd37, 1'b1};
        tbl[5] = '{8'd37,  8'd5,   8'd7,   8'd2,  1'b0};

        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quotient", quotient, 0);
        check("rst_remainder", remainder, 0);
        check("rst_dbz", div_by_zero, 0);
        reset = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].a, tbl[i].b, lat, nb, held);
            check($sformatf("tbl%0d_quotient", i), quotient, tbl[i].q);
            check($sformatf("tbl%0d_remainder", i), remainder, tbl[i].r);
            check($sformatf("tbl%0d_dbz", i), div_by_zero, tbl[i].z);
            check($sformatf("tbl%0d_latency", i), lat, (tbl[i].b == 0) ? 1 : W + 1);
            check($sformatf("tbl%0d_busy_cycles", i), nb, (tbl[i].b == 0) ? 0 : W);
            @(negedge clk);
            check($sformatf("tbl%0d_done_single", i), done, 0);
        end

        // Back to back: start held high through CALC and DONE.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        wait_done(lat, nb, held);
        check("b2b1_quotient", quotient, 66);
        check("b2b1_remainder", remainder, 2);
        check("b2b1_latency", lat, W + 1);
        dividend = 8'd17;
        divisor  = 8'd4;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(lat, nb, held);
        check("b2b2_latency", lat, W + 1);
        check("b2b2_busy_cycles", nb, W);
        check("b2b2_outputs_held", held, 1);
        check("b2b2_quotient", quotient, 4);
        check("b2b2_remainder", remainder, 1);

        // Start and operand changes during CALC must be ignored.
        @(negedge clk);
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd3;
        divisor  = 8'd1;
        @(negedge clk);
        start    = 1'b0;
        dividend = 8'd50;
        divisor  = 8'd50;
        wait_done(lat, nb, held);
        check("disturb_latency", lat + 4, W + 1);
        check("disturb_quotient", quotient, 14);
        check("disturb_remainder", remainder, 2);

        // Reset in the middle of CALC aborts with no done pulse.
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd3;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_quotient", quotient, 0);
        check("midrst_remainder", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (done) saw_done = 1'b1;
        end
        check("midrst_no_done", saw_done, 0);
        reset = 1'b1;
        do_op(8'd37, 8'd5, lat, nb, held);
        check("postrst_quotient", quotient, 7);
        check("postrst_remainder", remainder, 2);
        check("postrst_latency", lat, W + 1);

        // Random regression against plain integer division.
        for (int i = 0; i < 1000; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            int           eq;
            int           er;
            a = pick();
            b = pick();
            if (b == 0) begin
                eq = (1 << W) - 1;
                er = int'(a);
            end else begin
                eq = int'(a) / int'(b);
                er = int'(a) % int'(b);
            end
            do_op(a, b, lat, nb, held);
            check($sformatf("rnd%0d_quotient(%0d/%0d)", i, a, b), quotient, eq);
            check($sformatf("rnd%0d_remainder(%0d/%0d)", i, a, b), remainder, er);
            check($sformatf("rnd%0d_dbz", i), div_by_zero, (b == 0) ? 1 : 0);
            check($sformatf("rnd%0d_latency", i), lat, (b == 0) ? 1 : W + 1);
            if (b != 0) begin
                check($sformatf("rnd%0d_identity", i),
                      32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
                check($sformatf("rnd%0d_rem_lt_div", i), (remainder < b) ? 1 : 0, 1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/seq_restoring_divider.md
Name: seq_restoring_divider

Overview:
- Multi-cycle unsigned restoring divider built around one WIDTH+1-bit subtract datapath of the shared adder style: add_sub=1, cout=1 means no borrow.
- Holds a partial-remainder register, a dividend/quotient shift register and an iteration counter.
- An FSM sequences one quotient bit per clock.
- Sits beside the ALU as the multi-cycle DIV/MOD unit, with a start/busy/done handshake.

Parameters:
WIDTH, 8, operand, quotient and remainder width in bits (legal range 2..32)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
start  input  1  request; sampled only in IDLE or DONE
dividend  input  WIDTH  unsigned dividend; captured when start is accepted
divisor  input  WIDTH  unsigned divisor; captured when start is accepted
busy  output  1  high while in CALC
done  output  1  single-cycle pulse; result valid
quotient  output  WIDTH  registered quotient
remainder  output  WIDTH  registered remainder
div_by_zero  output  1  set with done when divisor was 0

Behaviour:
- Reset (reset=0, async): state=IDLE; R, Q, D, count cleared; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0. Reset mid-CALC aborts with no done pulse.
- States: IDLE, CALC, DONE.
- Output encoding: busy=(state==CALC), done=(state==DONE).
- Start accepted at edge k (state IDLE or DONE, start=1, divisor!=0):
  - R(WIDTH+1 bits)=0, Q=dividend, D=divisor, count=WIDTH.
  - div_by_zero cleared; state->CALC.
- Start with divisor==0 at edge k:
  - quotient={WIDTH{1}}, remainder=dividend, div_by_zero=1; state->DONE.
  - done is high in cycle k+1; no CALC cycles.
- CALC iteration (every edge while in CALC):
  - shifted_R = {R[WIDTH-1:0], Q[WIDTH-1]}; Q <<= 1.
  - trial = shifted_R - {0,D}, computed as a WIDTH+1-bit add of ~D with cin=1.
  - If cout=1: R=trial[WIDTH:0], Q[0]=1. Else R=shifted_R, Q[0]=0.
  - count decrements by 1.
- Exit from CALC: the edge that performs the iteration with count==1 also loads quotient=Q_next and remainder=R_next[WIDTH-1:0], and moves state->DONE.
- Timing:
  - busy is high between edges k and k+WIDTH.
  - done is high for exactly the one cycle following edge k+WIDTH.
  - Latency from the accepting edge to done is WIDTH+1 edges.
- DONE: if start=1 the next operation is accepted (back-to-back, no idle gap); otherwise state->IDLE.
- Holding: quotient, remainder and div_by_zero hold until the next accepted start. They stay unchanged throughout the next CALC and update only on its final edge.
- start while in CALC is ignored, and operand changes during CALC have no effect (operands were captured at accept).
- Invariants: R < 2·D before each iteration; final remainder < divisor; quotient·divisor + remainder == dividend (divisor!=0).

Test Plan:
- WIDTH=8, dividend=100, divisor=7, 1-cycle start pulse -> busy high 8 cycles; done pulse on 9th edge; quotient=14, remainder=2, div_by_zero=0.
- 255/1 -> quotient=255, remainder=0. 5/9 -> quotient=0, remainder=5. 255/255 -> quotient=1, remainder=0. Check all three end to end.
- 37/0 -> done one cycle after start, busy never high; quotient=255, remainder=37, div_by_zero=1. A following 37/5 clears the flag and gives quotient=7, remainder=2.
- Two ops back to back (start held through DONE), 200/3 then 17/4:
  - done pulses for 200/3 (quotient=66, remainder=2), then busy high 8 cycles, then done for 17/4 (quotient=4, remainder=1).
  - Outputs hold 66/2 during the second CALC.
- Mid-CALC disturbance:
  - start pulses and operand changes at cycle 3 of CALC are ignored; result matches the original operands.
  - reset=0 at cycle 4 clears all outputs immediately with no done pulse; a new start after release works.
- Random regression, 1000 operand pairs (including 0 and all-ones) -> quotient/remainder match the reference model; the identity holds; done latency is always WIDTH+1.
